trig_pulse_bank: RTL and testbench

Multi-channel, parametrised trigger/LED pulse generator for the acquisition/transmit timing path. Each channel has its own delay, pulse width, inter-pulse gap, repeat count and polarity. All channels share one arm/fire handshake, so one fire event produces a phase-aligned burst of pulse trains on up to NCH outputs. An abort input forces every output to its rest level. The block reports completion to the sequencer with a single-cycle done strobe.

---
 rtl/trig_pulse_bank.sv | 228 ++++++++++++++++++++++
 tb/tb_trig_pulse_bank.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/trig_pulse_bank.sv
// Multi-channel trigger/LED pulse generator: one shared arm/fire handshake
// launches phase-aligned delay/width/gap/repeat pulse trains on every channel.

module trig_pulse_ch #(
    parameter int DEL_W = 24,
    parameter int DUR_W = 16,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rest_level,
    input  logic             cfg_wr,
    input  logic [DEL_W-1:0] cfg_delay,
    input  logic [DUR_W-1:0] cfg_dur,
    input  logic [DUR_W-1:0] cfg_gap,
    input  logic [REP_W-1:0] cfg_repeat,
    input  logic             start,
    input  logic             stop,
    output logic             trig_out,
    output logic             enabled,
    output logic             at_done,
    output logic             next_done
);
    localparam int CNT_W = (DEL_W > DUR_W) ? DEL_W : DUR_W;

    localparam logic [2:0] CH_IDLE   = 3'd0;
    localparam logic [2:0] CH_DELAY  = 3'd1;
    localparam logic [2:0] CH_ACTIVE = 3'd2;
    localparam logic [2:0] CH_GAP    = 3'd3;
    localparam logic [2:0] CH_DONE   = 3'd4;

    logic [DEL_W-1:0] delay_q;
    logic [DUR_W-1:0] dur_q, gap_q;
    logic [REP_W-1:0] rep_q;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, gap_eff;
    logic [REP_W-1:0] rep_cnt, rep_nxt;

    // Config survives hard_stop; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            delay_q <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            rep_q   <= '0;
        end else if (cfg_wr) begin
            delay_q <= cfg_delay;
            dur_q   <= cfg_dur;
            gap_q   <= cfg_gap;
            rep_q   <= cfg_repeat;
        end
    end

    assign enabled = (dur_q != '0);
    assign gap_eff = (gap_q == '0) ? CNT_W'(1) : CNT_W'(gap_q);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rep_nxt   = rep_cnt;
        if (start) begin
            rep_nxt = rep_q;
            if (!enabled) begin
                state_nxt = CH_DONE;
                cnt_nxt   = '0;
            end else if (delay_q == '0) begin
                state_nxt = CH_ACTIVE;
                cnt_nxt   = CNT_W'(dur_q);
            end else begin
                state_nxt = CH_DELAY;
                cnt_nxt   = CNT_W'(delay_q);
            end
        end else begin
            case (state)
                CH_DELAY: begin
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = CH_ACTIVE;
                        cnt_nxt   = CNT_W'(dur_q);
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                CH_ACTIVE: begin
                    if (cnt <= CNT_W'(1)) begin
                        if (rep_cnt != '0) begin
                            state_nxt = CH_GAP;
                            cnt_nxt   = gap_eff;
                        end else begin
                            state_nxt = CH_DONE;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                CH_GAP: begin
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = CH_ACTIVE;
                        cnt_nxt   = CNT_W'(dur_q);
                        rep_nxt   = rep_cnt - REP_W'(1);
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign at_done   = (state == CH_DONE);
    assign next_done = (state_nxt == CH_DONE);

    always_ff @(posedge clk) begin
        if (!rst || stop) begin
            state    <= CH_IDLE;
            cnt      <= '0;
            rep_cnt  <= '0;
            trig_out <= rest_level;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rep_cnt  <= rep_nxt;
            trig_out <= (state_nxt == CH_ACTIVE) ? ~rest_level : rest_level;
        end
    end
endmodule

module trig_pulse_bank #(
    parameter int NCH   = 8,
    parameter int DEL_W = 24,
    parameter int DUR_W = 16,
    parameter int REP_W = 8,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   rest_level,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DEL_W-1:0] cfg_delay,
    input  logic [DUR_W-1:0] cfg_dur,
    input  logic [DUR_W-1:0] cfg_gap,
    input  logic [REP_W-1:0] cfg_repeat,
    input  logic             arm,
    input  logic             fire,
    input  logic             hard_stop,
    output logic [NCH-1:0]   trig_out,
    output logic             armed,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [CH_W:0] NCH_L = (CH_W+1)'(NCH);

    logic [1:0]     gstate;
    logic           start_q, busy_q, done_q;
    logic           fire_go, arm_go, cfg_ok;
    logic [NCH-1:0] ch_en, ch_at_done, ch_next_done;

    assign fire_go = !hard_stop && (gstate == ARMED) && fire;
    assign arm_go  = !hard_stop && (gstate == IDLE) && arm;
    assign cfg_ok  = cfg_we && !hard_stop && !fire_go && !arm_go &&
                     (gstate != RUN) && ({1'b0, cfg_ch} < NCH_L);

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            trig_pulse_ch #(.DEL_W(DEL_W), .DUR_W(DUR_W), .REP_W(REP_W)) u_ch (
                .clk        (clk),
                .rst        (rst),
                .rest_level (rest_level[i]),
                .cfg_wr     (cfg_ok && (cfg_ch == CH_W'(i))),
                .cfg_delay  (cfg_delay),
                .cfg_dur    (cfg_dur),
                .cfg_gap    (cfg_gap),
                .cfg_repeat (cfg_repeat),
                .start      (start_q),
                .stop       (hard_stop),
                .trig_out   (trig_out[i]),
                .enabled    (ch_en[i]),
                .at_done    (ch_at_done[i]),
                .next_done  (ch_next_done[i])
            );
        end
    endgenerate

    // Fire is registered into start_q so channels load one edge after fire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gstate  <= IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (hard_stop) begin
            gstate  <= IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= (gstate == RUN);
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (gstate)
                IDLE:  if (arm_go) gstate <= ARMED;
                ARMED: if (fire_go) begin
                    gstate  <= RUN;
                    start_q <= 1'b1;
                end
                RUN: begin
                    if (start_q) begin
                        busy_q <= 1'b1;
                        done_q <= ~|ch_en;
                    end else if (&ch_next_done) begin
                        gstate <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= ~&ch_at_done;
                    end
                end
                default: gstate <= IDLE;
            endcase
        end
    end

    assign armed = (gstate == ARMED);
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_trig_pulse_bank.sv
// Directed bench for trig_pulse_bank: bursts compared cycle by cycle against
// a pulse-window model built from the expected per-channel settings.

module tb_trig_pulse_bank;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rest_level;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [23:0] cfg_delay;
    logic [15:0] cfg_dur, cfg_gap;
    logic [7:0]  cfg_repeat;
    logic        arm, fire, hard_stop;
    logic [7:0]  trig_out;
    logic        armed, busy, done;

    int n_chk = 0;
    int n_fail = 0;
    int md[8], mw[8], mg[8], mr[8];

    trig_pulse_bank dut (
        .clk(clk), .rst(rst), .rest_level(rest_level),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
        .cfg_dur(cfg_dur), .cfg_gap(cfg_gap), .cfg_repeat(cfg_repeat),
        .arm(arm), .fire(fire), .hard_stop(hard_stop),
        .trig_out(trig_out), .armed(armed), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int d, input int w, input int g, input int r);
        cfg_ch = 3'(ch); cfg_delay = 24'(d); cfg_dur = 16'(w);
        cfg_gap = 16'(g); cfg_repeat = 8'(r); cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            md[i] = 0; mw[i] = 0; mg[i] = 0; mr[i] = 0;
        end
    endtask

    // Expected output t cycles after the fire edge.
    function automatic logic [7:0] exp_trig(input int t);
        logic [7:0] v = rest_level;
        for (int i = 0; i < 8; i++) begin
            int gp = (mg[i] == 0) ? 1 : mg[i];
            if (mw[i] != 0)
                for (int p = 0; p <= mr[i]; p++) begin
                    int s = 1 + md[i] + p * (mw[i] + gp);
                    if (t >= s && t <= s + mw[i] - 1) v[i] = ~rest_level[i];
                end
        end
        return v;
    endfunction

    function automatic int exp_done_t();
        int dt = 1;
        for (int i = 0; i < 8; i++) begin
            int gp = (mg[i] == 0) ? 1 : mg[i];
            int e = 1 + md[i] + (mr[i] + 1) * mw[i] + mr[i] * gp;
            if (mw[i] != 0 && e > dt) dt = e;
        end
        return dt;
    endfunction

    task automatic arm_fire();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("armed_rise", {31'd0, armed}, 32'd1);
        fire = 1'b1;
        tick();
        fire = 1'b0;
        chk("busy_at_k", {31'd0, busy}, 32'd0);
    endtask

    // inj: attempt a config write on ch2 while the burst runs.
    task automatic burst(input string tag, input int ncyc, input bit inj);
        int dt = exp_done_t();
        arm_fire();
        for (int t = 1; t <= ncyc; t++) begin
            if (inj && t == 2) begin
                cfg_ch = 3'd2; cfg_delay = 24'd0; cfg_dur = 16'd7;
                cfg_gap = 16'd3; cfg_repeat = 8'd0; cfg_we = 1'b1;
            end
            tick();
            cfg_we = 1'b0;
            chk({tag, "_trig"}, {24'd0, trig_out}, {24'd0, exp_trig(t)});
            chk({tag, "_done"}, {31'd0, done}, {31'd0, (t == dt)});
            chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (t < dt) || (t == 1 && dt == 1)});
        end
        chk({tag, "_armed_after"}, {31'd0, armed}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; rest_level = 8'hF0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_delay = '0; cfg_dur = '0; cfg_gap = '0; cfg_repeat = '0;
        arm = 1'b0; fire = 1'b0; hard_stop = 1'b0;
        model_clear();
        tick(); tick();
        chk("rst_trig", {24'd0, trig_out}, 32'hF0);
        chk("rst_armed", {31'd0, armed}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        rest_level = 8'h00;
        tick();
        chk("rest_follow", {24'd0, trig_out}, 32'h00);

        // Single channel: pulse on k+6..k+8, done at k+9.
        wr(0, 5, 3, 0, 0);
        md[0] = 5; mw[0] = 3;
        burst("single", 11, 1'b0);

        // Fire without arm is ignored.
        fire = 1'b1;
        tick();
        fire = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("noarm_busy", {31'd0, busy}, 32'd0);
            chk("noarm_trig", {24'd0, trig_out}, 32'h00);
        end

        // Inverted ch1 with repeats, ch0 disabled.
        rest_level = 8'h02;
        wr(0, 0, 0, 0, 0);
        wr(1, 0, 2, 4, 2);
        model_clear();
        mw[1] = 2; mg[1] = 4; mr[1] = 2;
        burst("repeat", 17, 1'b0);

        // Alignment: ch0 at k+1, ch3 at k+11, ch7 disabled.
        rest_level = 8'h00;
        wr(1, 0, 0, 0, 0);
        wr(0, 0, 1, 0, 0);
        wr(3, 10, 1, 0, 0);
        wr(7, 4, 0, 0, 0);
        model_clear();
        mw[0] = 1; md[3] = 10; mw[3] = 1;
        burst("align", 14, 1'b0);

        // gap=0 behaves as one rest cycle; write during RUN is dropped.
        wr(0, 0, 0, 0, 0);
        wr(3, 0, 0, 0, 0);
        wr(2, 1, 2, 0, 1);
        model_clear();
        md[2] = 1; mw[2] = 2; mr[2] = 1;
        burst("gap0", 9, 1'b1);
        burst("cfg_kept", 9, 1'b0);

        // Abort mid-pulse on ch3.
        wr(2, 0, 0, 0, 0);
        wr(3, 2, 5, 0, 0);
        model_clear();
        md[3] = 2; mw[3] = 5;
        arm_fire();
        for (int t = 1; t <= 4; t++) tick();
        chk("abort_pre", {24'd0, trig_out}, 32'h08);
        hard_stop = 1'b1;
        tick();
        hard_stop = 1'b0;
        chk("abort_trig", {24'd0, trig_out}, 32'h00);
        chk("abort_done", {31'd0, done}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("abort_done_once", {31'd0, done}, 32'd0);
        burst("rerun", 10, 1'b0);

        // Reset mid-burst clears config; next burst is all-disabled.
        arm_fire();
        for (int t = 1; t <= 4; t++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rstmid_trig", {24'd0, trig_out}, 32'h00);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_armed", {31'd0, armed}, 32'd0);
        model_clear();
        burst("empty", 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
